// File: rtl/change_dispenser.sv
// change_dispenser: pays out change largest-coin-first through a four-phase
// eject handshake; a coin whose mechanism never acks is masked for the rest of the job.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] change_amount,
  input  logic [4:0] hopper_empty,
  input  logic       eject_ack,
  output logic       eject_req,
  output logic [2:0] eject_sel,
  output logic       busy,
  output logic       done,
  output logic [8:0] dispensed_total,
  output logic [8:0] shortfall,
  output logic       error
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PICK, EJECT, RELEASE, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [8:0]    remaining_reg, remaining_next;
  logic [8:0]    dispensed_reg, dispensed_next;
  logic [8:0]    shortfall_reg, shortfall_next;
  logic [4:0]    fault_mask_reg, fault_mask_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    sel_reg, sel_next;
  logic          req_reg, req_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;

  logic [4:0]    eligible;
  logic          pick_found;
  logic [2:0]    pick_code;

  function automatic logic [8:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 9'd5;
      3'd1:    coin_value = 9'd10;
      3'd2:    coin_value = 9'd25;
      3'd3:    coin_value = 9'd50;
      3'd4:    coin_value = 9'd100;
      default: coin_value = 9'd0;
    endcase
  endfunction

  // A coin is usable if stocked, not faulted this job, and fits in what is still owed.
  for (genvar gi = 0; gi < 5; gi++) begin : g_eligible
    assign eligible[gi] = !hopper_empty[gi] && !fault_mask_reg[gi] &&
                          (coin_value(3'(gi)) <= remaining_reg);
  end

  // Ascending scan: the last hit is the largest eligible coin.
  always_comb begin
    pick_found = 1'b0;
    pick_code  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (eligible[i]) begin
        pick_found = 1'b1;
        pick_code  = 3'(i);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    dispensed_next  = dispensed_reg;
    shortfall_next  = shortfall_reg;
    fault_mask_next = fault_mask_reg;
    timer_next      = timer_reg;
    sel_next        = sel_reg;
    req_next        = req_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    error_next      = error_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next  = change_amount;
          dispensed_next  = 9'd0;
          shortfall_next  = 9'd0;
          error_next      = 1'b0;
          fault_mask_next = 5'd0;
          busy_next       = 1'b1;
          state_next      = PICK;
        end
      end
      PICK: begin
        if (pick_found) begin
          sel_next   = pick_code;
          req_next   = 1'b1;
          timer_next = '0;
          state_next = EJECT;
        end else begin
          // Result is loaded on the way into FINISH so it is valid alongside done.
          shortfall_next = remaining_reg;
          error_next     = (remaining_reg != 9'd0) || (fault_mask_reg != 5'd0);
          done_next      = 1'b1;
          state_next     = FINISH;
        end
      end
      EJECT: begin
        if (eject_ack) begin
          req_next       = 1'b0;
          remaining_next = remaining_reg - coin_value(sel_reg);
          dispensed_next = dispensed_reg + coin_value(sel_reg);
          state_next     = RELEASE;
        end else if (timer_reg == TIMEOUT_LAST) begin
          req_next        = 1'b0;
          fault_mask_next = fault_mask_reg | (5'd1 << sel_reg);
          state_next      = PICK;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      RELEASE: begin
        if (!eject_ack) state_next = PICK;
      end
      FINISH: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      remaining_reg  <= 9'd0;
      dispensed_reg  <= 9'd0;
      shortfall_reg  <= 9'd0;
      fault_mask_reg <= 5'd0;
      timer_reg      <= '0;
      sel_reg        <= 3'd0;
      req_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      dispensed_reg  <= dispensed_next;
      shortfall_reg  <= shortfall_next;
      fault_mask_reg <= fault_mask_next;
      timer_reg      <= timer_next;
      sel_reg        <= sel_next;
      req_reg        <= req_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  assign eject_req       = req_reg;
  assign eject_sel       = sel_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign dispensed_total = dispensed_reg;
  assign shortfall       = shortfall_reg;
  assign error           = error_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random payouts scored against a greedy
// payout reference model; a monitor checks each eject and each done pulse.
module tb_change_dispenser;
  localparam int ACK_TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] change_amount;
  logic [4:0] hopper_empty;
  logic       eject_ack;
  logic       eject_req;
  logic [2:0] eject_sel;
  logic       busy;
  logic       done;
  logic [8:0] dispensed_total;
  logic [8:0] shortfall;
  logic       error;

  change_dispenser #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
    .hopper_empty(hopper_empty), .eject_ack(eject_ack), .eject_req(eject_req),
    .eject_sel(eject_sel), .busy(busy), .done(done),
    .dispensed_total(dispensed_total), .shortfall(shortfall), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int amount;
    int disp;
    int sf;
    int err;
    int start_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         exp_sel_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_seen = 0;
  int         txn_id = 0;
  int         cur_start_cyc = 0;
  logic [4:0] dead_mask = 5'd0;
  int         ack_delay = 1;
  int         coin_val[5] = '{5, 10, 25, 50, 100};

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: repeatedly take the largest stocked, unfaulted coin that fits;
  // a dead coin costs one attempt and is then excluded.
  task automatic push_model(input int amount, input logic [4:0] hop0,
                            input logic [4:0] hop1, input logic [4:0] dead,
                            output int attempts);
    int         rem;
    int         pick;
    logic [4:0] mask;
    logic [4:0] hop;
    exp_t       e;
    rem = amount;
    mask = 5'd0;
    attempts = 0;
    e.amount = amount;
    e.disp = 0;
    do begin
      hop = (attempts == 0) ? hop0 : hop1;
      pick = -1;
      for (int i = 0; i < 5; i++)
        if (!hop[i] && !mask[i] && coin_val[i] <= rem) pick = i;
      if (pick >= 0) begin
        exp_sel_q.push_back(pick);
        attempts++;
        if (dead[pick]) mask[pick] = 1'b1;
        else begin
          rem -= coin_val[pick];
          e.disp += coin_val[pick];
        end
      end
    end while (pick >= 0);
    e.sf = rem;
    e.err = ((rem != 0) || (mask != 5'd0)) ? 1 : 0;
    e.start_cyc = cur_start_cyc;
    exp_q.push_back(e);
  endtask

  // Coin mechanism: acks live coins after ack_delay request cycles, drops ack once req falls.
  initial begin : coin_mech
    int cnt = 0;
    eject_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (eject_req === 1'b1 && !eject_ack && !dead_mask[eject_sel]) begin
        cnt++;
        if (cnt >= ack_delay) begin
          eject_ack = 1'b1;
          cnt = 0;
        end
      end else if (eject_req !== 1'b1) begin
        cnt = 0;
        eject_ack = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic       prev_req = 1'b0;
    logic       prev_done = 1'b0;
    logic       first_ej = 1'b1;
    int         req_len = 0;
    logic [2:0] req_sel = 3'd0;
    int         es;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        prev_done = 1'b0;
        first_ej = 1'b1;
      end else begin
        if (prev_done) begin
          check_eq("done_pulse_width", done, 0);
          check_eq("busy_after_done", busy, 0);
        end
        if (eject_req && !prev_req) begin
          req_len = 1;
          req_sel = eject_sel;
          if (exp_sel_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_eject: got sel %0d, expected no eject", eject_sel);
          end else begin
            es = exp_sel_q.pop_front();
            check_eq("eject_sel", eject_sel, es);
          end
          if (first_ej) begin
            check_eq("first_eject_latency", cyc, cur_start_cyc + 2);
            check_eq("busy_during_eject", busy, 1);
            first_ej = 1'b0;
          end
        end else if (eject_req) begin
          req_len++;
          check_eq("eject_sel_stable", eject_sel, req_sel);
        end else if (prev_req) begin
          check_eq("eject_req_len", req_len, dead_mask[req_sel] ? ACK_TO : ack_delay);
        end
        prev_req = eject_req;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done, expected none");
          end else begin
            e = exp_q.pop_front();
            check_eq("dispensed_total", dispensed_total, e.disp);
            check_eq("shortfall", shortfall, e.sf);
            check_eq("error", error, e.err);
            check_eq("total_plus_shortfall", int'(dispensed_total) + int'(shortfall), e.amount);
            check_eq("missing_ejects", exp_sel_q.size(), 0);
            check_eq("busy_with_done", busy, 1);
            if (e.amount == 0) check_eq("zero_done_latency", cyc, e.start_cyc + 2);
            $display("txn %0d: amount=%0d dispensed=%0d shortfall=%0d error=%0d",
                     txn_id, e.amount, dispensed_total, shortfall, error);
          end
          txn_id++;
          done_seen++;
          first_ej = 1'b1;
        end
        prev_done = done;
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_sel_q.delete();
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_txn(input int amount, input logic [4:0] hop0, input logic [4:0] hop1,
                         input logic [4:0] dead, input int delay, input bit extra_start);
    int attempts;
    int target;
    int waited;
    dead_mask = dead;
    ack_delay = delay;
    hopper_empty = hop0;
    change_amount = 9'(amount);
    cur_start_cyc = cyc;
    target = done_seen + 1;
    push_model(amount, hop0, hop1, dead, attempts);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    change_amount = 9'($urandom_range(0, 511));
    if (attempts > 0 && (extra_start || hop1 != hop0)) begin
      waited = 0;
      while (!eject_req && waited < 50) begin
        @(posedge clk); #1;
        waited++;
      end
      hopper_empty = hop1;
      if (extra_start) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    waited = 0;
    while (done_seen < target && waited < 600) begin
      @(posedge clk); #1;
      waited++;
    end
    if (done_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done for amount %0d",
               waited, amount);
      pulse_reset();
    end
  endtask

  task automatic reset_abort();
    int waited = 0;
    dead_mask = 5'd0;
    ack_delay = 1;
    hopper_empty = 5'd0;
    change_amount = 9'd150;
    cur_start_cyc = cyc;
    exp_sel_q.push_back(4);
    exp_sel_q.push_back(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(eject_req && dispensed_total != 9'd0) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("abort_mid_eject", eject_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_eject_req", eject_req, 0);
    check_eq("abort_eject_sel", eject_sel, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_dispensed", dispensed_total, 0);
    check_eq("abort_shortfall", shortfall, 0);
    check_eq("abort_error", error, 0);
    exp_sel_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int         amt;
    int         dly;
    logic [4:0] h0;
    logic [4:0] h1;
    logic [4:0] dd;
    reset = 1'b1;
    start = 1'b0;
    change_amount = 9'd0;
    hopper_empty = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_eject_req", eject_req, 0);
    check_eq("rst_eject_sel", eject_sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dispensed", dispensed_total, 0);
    check_eq("rst_shortfall", shortfall, 0);
    check_eq("rst_error", error, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_txn(85, 5'b00000, 5'b00000, 5'b00000, 2, 1'b0);
    run_txn(30, 5'b00100, 5'b00100, 5'b00000, 2, 1'b0);
    run_txn(25, 5'b00000, 5'b00000, 5'b00100, 1, 1'b0);
    run_txn(17, 5'b00000, 5'b00000, 5'b00000, 1, 1'b0);
    run_txn(0, 5'b00000, 5'b00000, 5'b00000, 1, 1'b0);
    run_txn(100, 5'b00000, 5'b00000, 5'b00000, 3, 1'b1);
    run_txn(20, 5'b00000, 5'b00010, 5'b00000, 2, 1'b0);
    run_txn(50, 5'b00000, 5'b00000, 5'b00000, ACK_TO, 1'b0);
    run_txn(511, 5'b00000, 5'b00000, 5'b00000, 1, 1'b0);
    run_txn(40, 5'b11111, 5'b11111, 5'b00000, 1, 1'b0);
    run_txn(65, 5'b00000, 5'b00000, 5'b11000, 2, 1'b0);
    reset_abort();
    run_txn(85, 5'b00000, 5'b00000, 5'b00000, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      amt = $urandom_range(0, 511);
      h0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      h1 = ($urandom_range(0, 3) == 0) ? (h0 | 5'(1 << $urandom_range(0, 4))) : h0;
      dd = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      dly = $urandom_range(1, ACK_TO);
      run_txn(amt, h0, h1, dd, dly, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, max cycles eject_req may wait for eject_ack before the hopper is declared faulted.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle request to pay out change_amount.
REQ-006 change_amount  input  9  change owed in cents (0-511), sampled when start is accepted.
REQ-007 hopper_empty  input  5  per-denomination empty sensor; bit index = coin code.
REQ-008 eject_ack  input  1  coin-mechanism acknowledge of a four-phase eject handshake.
REQ-009 eject_req  output  1  eject request to the coin mechanism.
REQ-010 eject_sel  output  3  coin code being ejected: 0=5c, 1=10c, 2=25c, 3=50c, 4=100c.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse at end of transaction.
REQ-013 dispensed_total  output  9  cents actually ejected in current/last transaction.
REQ-014 shortfall  output  9  cents still owed at done.
REQ-015 error  output  1  high with done when shortfall is nonzero or any hopper faulted; held until next accepted start.

Function
REQ-016 States SHALL be IDLE, PICK, EJECT, RELEASE, FINISH; all outputs registered.
REQ-017 IDLE: start=1 SHALL load remaining<=change_amount, clear dispensed_total, shortfall, error and fault mask, and go to PICK; busy=1 from next cycle.
REQ-018 start while not in IDLE SHALL be ignored.
REQ-019 PICK (one cycle): select the largest coin with value <= remaining, hopper_empty bit 0, fault-mask bit 0; if found, set eject_sel and go to EJECT.
REQ-020 PICK with remaining=0 or no eligible coin SHALL go to FINISH.
REQ-021 EJECT: eject_req=1 with eject_sel stable; on eject_ack=1, deassert eject_req, subtract coin value from remaining, add it to dispensed_total, go to RELEASE.
REQ-022 EJECT timeout: after ACK_TIMEOUT cycles without eject_ack, deassert eject_req, set fault-mask bit for eject_sel, go to PICK; no subtraction.
REQ-023 RELEASE: wait for eject_ack=0, then go to PICK; eject_req SHALL stay 0.
REQ-024 FINISH (one cycle): shortfall<=remaining, error<=(remaining!=0)|(fault mask!=0), done=1, busy=0 next cycle, go to IDLE.
REQ-025 Amounts not a multiple of 5 SHALL pay the rounded-down value; residual (1-4c) appears in shortfall with error=1.
REQ-026 Latency: start at cycle N, PICK at N+1, eject_req first high at N+2.
REQ-027 dispensed_total + shortfall SHALL equal the accepted change_amount at done.
REQ-028 hopper_empty rising during EJECT SHALL NOT abort the current eject; it applies from the next PICK.
REQ-029 Arithmetic SHALL be 9-bit unsigned; remaining SHALL never underflow (guaranteed by REQ-019).

Reset
REQ-030 reset=1 SHALL force IDLE and clear eject_req, eject_sel, busy, done, dispensed_total, shortfall, error, remaining, timeout counter and fault mask to 0 at the next edge.
REQ-031 reset mid-transaction SHALL abandon the payout immediately; eject_req low the cycle after reset is sampled.

Verification
REQ-032 change_amount=85, all hoppers full, ack after 2 cycles -> eject_sel sequence 3,2,1; dispensed_total=85, shortfall=0, error=0, one done pulse.
REQ-033 change_amount=30, hopper_empty=5'b00100 -> three ejects with eject_sel=1; dispensed_total=30, error=0.
REQ-034 change_amount=25, ACK_TIMEOUT=4, quarter never acks -> timeout after 4 cycles, then 10,10,5 paid; dispensed_total=25, shortfall=0, error=1.
REQ-035 change_amount=17, all full -> 10,5 paid; shortfall=2, error=1.
REQ-036 change_amount=0 -> no eject_req; done at cycle N+2, shortfall=0, error=0; second start while busy on a 100c job ignored.
REQ-037 reset asserted while eject_req=1 -> all outputs 0 next cycle, state IDLE, new start accepted normally.
